// File: rtl/async_fifo_package.sv
// Shared types and constants for the async FIFO and its frame reader.
package async_fifo_package;

   localparam int DATA_WIDTH = 16;

   // Width of the header length field and of the remaining-word counter.
   localparam int LEN_W = 8;

   // Position of the length field inside a header word; bits above are reserved.
   localparam int HDR_LEN_LSB = 0;
   localparam int HDR_LEN_MSB = LEN_W - 1;

   typedef enum logic [1:0] {
      HEADER  = 2'd0,
      PAYLOAD = 2'd1,
      DROP    = 2'd2
   } frame_state_t;

endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready register slice carrying a data word and a last flag.
// Handshake: a beat moves when valid_o && ready_i; the slice may be loaded
// whenever can_load_o is high, and a load together with a transfer replaces
// the held contents in the same cycle.
module stream_out_reg #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         last_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         last_o,
   output logic         can_load_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;
   logic         last_q, last_d;

   // Next contents: load wins, otherwise a transfer empties the slice.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         last_d  = last_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Slice storage, cleared asynchronously so a held beat vanishes on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign valid_o    = valid_q;
   assign data_o     = data_q;
   assign last_o     = last_q;
   assign can_load_o = ~valid_q | ready_i;

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains the FIFO read port and splits the word stream into length-prefixed
// frames. Legal payloads go out through a registered stream slice; frames
// whose length exceeds MAX_LEN are popped and thrown away.
// Handshakes: FIFO pop on f_valid && f_ready, downstream beat on
// m_valid && m_ready; f_ready never looks at f_valid.
module fifo_frame_reader
   import async_fifo_package::*;
#(
   parameter int DATA_WIDTH = async_fifo_package::DATA_WIDTH,
   parameter int MAX_LEN    = 64
) (
   input  logic                  rclk,
   input  logic                  rrst_n,
   input  logic                  f_valid,
   input  logic [DATA_WIDTH-1:0] f_data,
   output logic                  f_ready,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  frame_done,
   output logic                  len_err,
   output logic [15:0]           frame_count,
   output frame_state_t          dbg_state_o
);

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   frame_state_t     state_q;
   logic [LEN_W-1:0] rem_q;
   logic             run_q;
   logic             frame_done_q;
   logic             len_err_q;
   logic [15:0]      count_q, count_d;

   logic [LEN_W-1:0] hdr_len;
   logic             ready_raw;
   logic             pop;
   logic             load;
   logic             hdr_zero;
   logic             last_beat;
   logic             out_can_load;

   assign hdr_len = f_data[HDR_LEN_MSB:HDR_LEN_LSB];

   // Pop permission per state; run_q keeps f_ready low until the first edge after reset.
   always_comb begin
      ready_raw = 1'b0;
      unique case (state_q)
         HEADER:  ready_raw = 1'b1;
         PAYLOAD: ready_raw = out_can_load;
         DROP:    ready_raw = 1'b1;
         default: ready_raw = 1'b0;
      endcase
      f_ready = run_q & ready_raw;
   end

   assign pop       = f_valid & f_ready;
   assign load      = pop & (state_q == PAYLOAD);
   assign hdr_zero  = pop & (state_q == HEADER) & (hdr_len == '0);
   assign last_beat = m_valid & m_ready & m_last;

   // Completed legal frames: an empty-frame header and a final beat can land on the same edge.
   always_comb begin
      count_d = count_q + 16'(last_beat) + 16'(hdr_zero);
   end

   // Frame parser: state, remaining count and registered status pulses.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q      <= HEADER;
         rem_q        <= '0;
         run_q        <= 1'b0;
         frame_done_q <= 1'b0;
         len_err_q    <= 1'b0;
         count_q      <= '0;
      end else begin
         run_q        <= 1'b1;
         frame_done_q <= last_beat | hdr_zero;
         len_err_q    <= 1'b0;
         count_q      <= count_d;
         unique case (state_q)
            HEADER: begin
               if (pop && (hdr_len != '0)) begin
                  rem_q <= hdr_len;
                  if (hdr_len > MAX_LEN_L) begin
                     state_q   <= DROP;
                     len_err_q <= 1'b1;
                  end else begin
                     state_q <= PAYLOAD;
                  end
               end
            end
            PAYLOAD, DROP: begin
               if (pop) begin
                  rem_q <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     state_q <= HEADER;
                  end
               end
            end
            default: state_q <= HEADER;
         endcase
      end
   end

   stream_out_reg #(
      .W(DATA_WIDTH)
   ) u_out (
      .clk_i      (rclk),
      .rst_ni     (rrst_n),
      .load_i     (load),
      .data_i     (f_data),
      .last_i     (rem_q == LEN_W'(1)),
      .ready_i    (m_ready),
      .valid_o    (m_valid),
      .data_o     (m_data),
      .last_o     (m_last),
      .can_load_o (out_can_load)
   );

   assign frame_done  = frame_done_q;
   assign len_err     = len_err_q;
   assign frame_count = count_q;
   assign dbg_state_o = state_q;

endmodule
